// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite types and defaults for the register-bank responder.
package axi_lite_pkg;

    localparam int unsigned AXI_ADDR_W = 8;
    localparam int unsigned AXI_DATA_W = 32;

    typedef logic [1:0] resp_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;

    typedef enum logic {
        W_COLLECT,
        W_RESP
    } wstate_t;

endpackage

// File: rtl/axi_lite_regfile.sv
// Register storage: one byte-strobed write port, one combinational read port.
module axi_lite_regfile #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned IDX_W    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_we,
    input  logic [IDX_W-1:0]    i_widx,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W/8-1:0] i_wstrb,
    input  logic [IDX_W-1:0]    i_ridx,
    output logic [DATA_W-1:0]   o_rdata
);

    logic [DATA_W-1:0] r_mem [NUM_REGS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '{default: '0};
        end else if (i_we) begin
            for (int unsigned b = 0; b < DATA_W/8; b++) begin
                if (i_wstrb[b]) begin
                    r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder over a bank of memory-mapped registers.
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_W   = AXI_ADDR_W,
    parameter int unsigned DATA_W   = AXI_DATA_W,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic                bvalid,
    input  logic                bready,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ADDR_W-1:0]   araddr,
    output logic                rvalid,
    input  logic                rready,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp
);

    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int unsigned STRB_W = DATA_W / 8;

    wstate_t             r_wstate;
    wstate_t             w_wstate_nxt;
    logic                r_aw_held;
    logic [IDX_W-1:0]    r_awidx;
    logic                r_w_held;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    resp_t               r_bresp;
    logic                r_rvalid;
    logic [DATA_W-1:0]   r_rdata;
    resp_t               r_rresp;

    logic                w_bvalid;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_ar_hs;
    logic                w_commit;
    logic [IDX_W-1:0]    w_widx;
    logic [DATA_W-1:0]   w_wdata;
    logic [STRB_W-1:0]   w_wstrb;
    logic                w_wr_in_range;
    logic [IDX_W-1:0]    w_ridx;
    logic                w_rd_in_range;
    logic [DATA_W-1:0]   w_rf_rdata;
    logic                w_unused_addr_lsbs;

    assign w_bvalid = (r_wstate == W_RESP);
    assign awready  = !rst && !r_aw_held && !w_bvalid;
    assign wready   = !rst && !r_w_held && !w_bvalid;
    assign arready  = !rst && !r_rvalid;

    assign w_aw_hs  = awvalid && awready;
    assign w_w_hs   = wvalid && wready;
    assign w_ar_hs  = arvalid && arready;

    // Address and data may come from the held copy or from this cycle's handshake.
    assign w_commit = !w_bvalid && (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    assign w_widx   = r_aw_held ? r_awidx : awaddr[ADDR_W-1:2];
    assign w_wdata  = r_w_held ? r_wdata : wdata;
    assign w_wstrb  = r_w_held ? r_wstrb : wstrb;

    assign w_wr_in_range = 32'(w_widx) < NUM_REGS;
    assign w_ridx        = araddr[ADDR_W-1:2];
    assign w_rd_in_range = 32'(w_ridx) < NUM_REGS;

    assign w_unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

    axi_lite_regfile #(
        .NUM_REGS (NUM_REGS),
        .DATA_W   (DATA_W),
        .IDX_W    (RIDX_W)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_commit && w_wr_in_range),
        .i_widx  (w_widx[RIDX_W-1:0]),
        .i_wdata (w_wdata),
        .i_wstrb (w_wstrb),
        .i_ridx  (w_ridx[RIDX_W-1:0]),
        .o_rdata (w_rf_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate <= W_COLLECT;
        end else begin
            r_wstate <= w_wstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_COLLECT: if (w_commit) w_wstate_nxt = W_RESP;
            W_RESP:    if (bready)   w_wstate_nxt = W_COLLECT;
            default:                 w_wstate_nxt = W_COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_aw_held <= 1'b0;
            r_awidx   <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bresp   <= RESP_OKAY;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bresp   <= w_wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awidx   <= awaddr[ADDR_W-1:2];
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= wdata;
                    r_wstrb  <= wstrb;
                end
            end

            // Regfile read is combinational, so a same-edge write yields the old value.
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_in_range ? w_rf_rdata : '0;
                r_rresp  <= w_rd_in_range ? RESP_OKAY : RESP_SLVERR;
            end else if (r_rvalid && rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign bvalid = w_bvalid;
    assign bresp  = r_bresp;
    assign rvalid = r_rvalid;
    assign rdata  = r_rdata;
    assign rresp  = r_rresp;

endmodule

// File: doc/axi_lite_slave_regs.md
Name: axi_lite_slave_regs

Overview:
AXI4-Lite responder (slave) fronting a bank of NUM_REGS memory-mapped DATA_W-bit registers.
- Independent write channels (AW, W, B) and read channels (AR, R).
- Sits behind the interconnect, opposite the AXI master; drives the ready/response side of the handshakes our bus checker monitors.
- Ready behaviour is chosen so the checker's rules hold: awready/arready are already high when a new valid rises, and wready is high within 1 cycle.

Parameters:
ADDR_W, 8, byte address width
DATA_W, 32, data width (fixed at 32 for AXI-Lite; parameterised for the package)
NUM_REGS, 16, number of registers; word index = addr[ADDR_W-1:2]

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
awvalid  in  1  write address valid
awready  out  1  write address ready
awaddr  in  ADDR_W  write byte address
wvalid  in  1  write data valid
wready  out  1  write data ready
wdata  in  DATA_W  write data
wstrb  in  DATA_W/8  byte enables
bvalid  out  1  write response valid
bready  in  1  write response ready
bresp  out  2  write response
arvalid  in  1  read address valid
arready  out  1  read address ready
araddr  in  ADDR_W  read byte address
rvalid  out  1  read data valid
rready  in  1  read data ready
rdata  out  DATA_W  read data
rresp  out  2  read response

Behaviour:
- Reset (async, rst=1): all registers = 0; aw_held, w_held, bvalid, rvalid = 0; bresp, rresp, rdata = 0; awready, wready, arready forced 0 while rst=1.
- Address decode: idx = addr[ADDR_W-1:2]; addr[1:0] ignored; idx >= NUM_REGS -> SLVERR (2'b10), else OKAY (2'b00).
- Write path, states W_COLLECT and W_RESP:
  - awready = !rst & !aw_held & !bvalid (combinational from state).
  - wready = !rst & !w_held & !bvalid.
  - An AW handshake captures awaddr into aw_held; a W handshake captures wdata/wstrb into w_held. Either order is accepted, including the same cycle.
  - At the edge where an address and data are both available (held, or handshaking that cycle), the write commits: each byte with wstrb[i]=1 is written. A SLVERR address writes nothing.
  - On that same edge: bvalid<=1, bresp set, both held flags cleared -> W_RESP.
  - Latency: AW+W in the same cycle -> bvalid the next cycle.
  - W_RESP: bvalid and bresp stable until bready; on bvalid&bready -> bvalid<=0, back to W_COLLECT. awready/wready are 0 throughout W_RESP.
  - wstrb=0 with a valid address: no change, OKAY.
- Read path:
  - arready = !rst & !rvalid.
  - On an AR handshake: rdata <= reg[idx] (0 if out of range), rresp set, rvalid<=1 at the next edge.
  - rvalid, rdata and rresp are held stable until rready; on rvalid&rready -> rvalid<=0. A new AR can be accepted the cycle after that.
- Read/write collision: a read sampling on the same edge a write commits to the same register returns the old value.
- Read and write paths are fully concurrent; neither stalls the other.
- Reset mid-transaction: all held state and pending responses are dropped; no response is issued for the aborted transaction.

Decomposition:
- Package axi_lite_pkg: resp_t (2-bit) with RESP_OKAY=2'b00 and RESP_SLVERR=2'b10; default ADDR_W/DATA_W constants; write-state enum (W_COLLECT, W_RESP).
- Sub-module axi_lite_regfile:
  - NUM_REGS x DATA_W storage with async reset to 0.
  - One byte-strobed write port: we, widx, wdata, wstrb.
  - One combinational read port: ridx -> rdata.
- Top module: handshake/FSM logic and address decode.

Test Plan:
- Simultaneous AW/W, awaddr=0x04, wdata=0xDEADBEEF, wstrb=4'hF, bready=1 -> bvalid=1 one cycle later with bresp=00; a following read of 0x04 gives rvalid next cycle, rdata=0xDEADBEEF, rresp=00.
- W two cycles before AW (wdata=0x12345678 to 0x08) -> wready drops after the W handshake, awready stays 1; bvalid the cycle after AW; reg[2]=0x12345678.
- Write 0xFFFFFFFF to 0x0C, then wstrb=4'b0010 with wdata=0x0000AB00 -> readback 0xFFFFABFF.
- awaddr=0x40 (idx 16) -> bresp=10, no register changes; araddr=0x40 -> rresp=10, rdata=0.
- Hold bready=0 for 5 cycles -> bvalid and bresp stable, awready=wready=0 throughout; hold rready=0 -> rvalid/rdata stable, arready=0.
- Assert rst with AW held and rvalid=1 -> outputs 0 immediately (async); after release, awready/wready/arready=1 and all registers read 0.
